// File: rtl/btb_predictor.sv
`default_nettype none
//============================================================================
// Module   : btb_predictor
// Purpose  : Direct-mapped branch target buffer with per-entry saturating
//            direction counters. Supplies the fetch stage with a registered
//            taken/target prediction and is trained by resolved branches.
//            A clear sequencer walks every entry after reset or flush so
//            that all storage has a single write port and no reset, which
//            lets it map onto RAM.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk           clock
//   rst_n         synchronous active-low reset
//   lookup_valid  fetch requests a prediction for lookup_pc
//   lookup_pc     fetch PC
//   stall         hold all pred_* outputs, ignore the lookup
//   pred_valid    prediction registers hold a lookup result
//   pred_taken    predict taken
//   pred_target   predicted target (meaningful when pred_taken=1)
//   upd_valid     resolved control-transfer instruction
//   upd_pc        PC of the resolved instruction
//   upd_taken     actual direction
//   upd_target    actual target
//   flush_all     invalidate every entry
//   busy          clear sequence in progress
//============================================================================
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    input  logic        stall,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush_all,
    output logic        busy
);

    localparam int                 c_IDX_W    = $clog2(ENTRIES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(ENTRIES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [CTR_W-1:0]   c_CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0]   c_CTR_MAX  = '1;
    // Weakly-taken: only the MSB set (equals 1 when CTR_W=1)
    localparam logic [CTR_W-1:0]   c_CTR_WEAK = c_CTR_ONE << (CTR_W - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Entry storage (no reset; invalidated by the clear sequencer)
    // ------------------------------------------------------------------
    logic               mem_valid_q [ENTRIES];
    logic [TAG_W-1:0]   mem_tag_q   [ENTRIES];
    logic [31:0]        mem_tgt_q   [ENTRIES];
    logic [CTR_W-1:0]   mem_ctr_q   [ENTRIES];

    state_t             state_q, state_d;
    logic [c_IDX_W-1:0] clear_idx_q, clear_idx_d;

    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [31:0]        pred_target_q, pred_target_d;

    // Only the index and tag fields of either PC are used
    logic w_unused_pc;
    assign w_unused_pc = ^{lookup_pc, upd_pc};

    assign busy = (state_q == S_CLEAR);

    // ------------------------------------------------------------------
    // Lookup read port
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic [CTR_W-1:0]   w_lk_ctr;

    assign w_lk_idx = lookup_pc[c_IDX_W+1:2];
    assign w_lk_tag = lookup_pc[c_IDX_W+1+TAG_W:c_IDX_W+2];
    assign w_lk_hit = mem_valid_q[w_lk_idx] && (mem_tag_q[w_lk_idx] == w_lk_tag);
    assign w_lk_ctr = mem_ctr_q[w_lk_idx];

    always_comb begin
        pred_valid_d  = pred_valid_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (!stall) begin
            pred_valid_d  = lookup_valid;
            pred_taken_d  = lookup_valid && w_lk_hit && w_lk_ctr[CTR_W-1] && !busy;
            pred_target_d = w_lk_hit ? mem_tgt_q[w_lk_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'h0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_target = pred_target_q;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        case (state_q)
            S_IDLE: begin
                if (flush_all) begin
                    state_d     = S_CLEAR;
                    clear_idx_d = '0;
                end
            end
            S_CLEAR: begin
                if (flush_all) begin
                    clear_idx_d = '0;
                end else begin
                    clear_idx_d = clear_idx_q + c_IDX_ONE;
                    if (clear_idx_q == c_LAST_IDX) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_CLEAR;
                clear_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Update read port and single shared write port
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic [CTR_W-1:0]   w_up_ctr;
    logic               w_up_en;

    assign w_up_idx = upd_pc[c_IDX_W+1:2];
    assign w_up_tag = upd_pc[c_IDX_W+1+TAG_W:c_IDX_W+2];
    assign w_up_hit = mem_valid_q[w_up_idx] && (mem_tag_q[w_up_idx] == w_up_tag);
    assign w_up_ctr = mem_ctr_q[w_up_idx];
    // A flush in the same cycle wins over the update
    assign w_up_en  = upd_valid && !busy && !flush_all;

    logic               w_we;
    logic [c_IDX_W-1:0] w_waddr;
    logic               w_wvalid;
    logic [TAG_W-1:0]   w_wtag;
    logic [31:0]        w_wtgt;
    logic [CTR_W-1:0]   w_wctr;

    always_comb begin
        w_we     = 1'b0;
        w_waddr  = clear_idx_q;
        w_wvalid = 1'b0;
        w_wtag   = '0;
        w_wtgt   = 32'h0;
        w_wctr   = '0;
        // Storage is left untouched while reset is held; the sequence
        // started on release takes care of invalidation.
        if (rst_n) begin
            if (busy) begin
                w_we = 1'b1;
            end else if (w_up_en) begin
                w_waddr = w_up_idx;
                if (w_up_hit) begin
                    w_we     = 1'b1;
                    w_wvalid = 1'b1;
                    w_wtag   = w_up_tag;
                    if (upd_taken) begin
                        w_wtgt = upd_target;
                        w_wctr = (w_up_ctr == c_CTR_MAX) ? w_up_ctr : w_up_ctr + c_CTR_ONE;
                    end else begin
                        w_wtgt = mem_tgt_q[w_up_idx];
                        w_wctr = (w_up_ctr == '0) ? w_up_ctr : w_up_ctr - c_CTR_ONE;
                    end
                end else if (upd_taken) begin
                    w_we     = 1'b1;
                    w_wvalid = 1'b1;
                    w_wtag   = w_up_tag;
                    w_wtgt   = upd_target;
                    w_wctr   = c_CTR_WEAK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_valid_q[w_waddr] <= w_wvalid;
            mem_tag_q[w_waddr]   <= w_wtag;
            mem_tgt_q[w_waddr]   <= w_wtgt;
            mem_ctr_q[w_waddr]   <= w_wctr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor.sv
`default_nettype none
//============================================================================
// Module   : tb_btb_predictor
// Purpose  : Self-checking bench for btb_predictor: directed scenarios
//            followed by random traffic, every cycle compared against an
//            array-based reference model of the predictor.
// Revision : 1.0 - initial release
//============================================================================
module tb_btb_predictor;

    localparam int ENTRIES  = 16;
    localparam int TAG_W    = 8;
    localparam int CTR_W    = 2;
    localparam int IDX_W    = $clog2(ENTRIES);
    localparam int CTR_HALF = 2 ** (CTR_W - 1);
    localparam int CTR_TOP  = 2 ** CTR_W - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        stall;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush_all;
    logic        busy;

    always #5 clk = ~clk;

    btb_predictor #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CTR_W   (CTR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .stall        (stall),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .flush_all    (flush_all),
        .busy         (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: table of entries plus remaining clear cycles
    bit          m_known [ENTRIES];
    bit          m_val   [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_rem = 0;
    bit          m_pv = 0, m_pt = 0, m_ptgt_known = 0;
    logic [31:0] m_ptgt = 0;

    function automatic int unsigned f_idx(logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned f_tag(logic [31:0] pc);
        return (pc >> (IDX_W + 2)) % (2 ** TAG_W);
    endfunction

    task automatic model_step();
        int unsigned i, t;
        bit hit, mbusy;
        if (!rst_n) begin
            m_pv = 0; m_pt = 0; m_ptgt = 0; m_ptgt_known = 1;
            m_rem = ENTRIES;
            return;
        end
        mbusy = (m_rem > 0);
        if (!stall) begin
            i = f_idx(lookup_pc);
            hit = 0;
            if (m_known[i]) begin
                hit = m_val[i] && (m_tag[i] == f_tag(lookup_pc));
                m_ptgt = hit ? m_tgt[i] : 32'h0;
                m_ptgt_known = 1;
            end else begin
                m_ptgt_known = 0;
            end
            m_pv = lookup_valid;
            m_pt = lookup_valid && !mbusy && hit && (m_ctr[i] >= CTR_HALF);
        end
        if (mbusy) begin
            i = ENTRIES - m_rem;
            m_known[i] = 1;
            m_val[i]   = 0;
            m_rem = flush_all ? ENTRIES : m_rem - 1;
        end else if (flush_all) begin
            m_rem = ENTRIES;
        end else if (upd_valid) begin
            i = f_idx(upd_pc);
            t = f_tag(upd_pc);
            if (m_val[i] && m_tag[i] == t) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[i] + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (upd_taken) begin
                m_val[i] = 1;
                m_tag[i] = t;
                m_tgt[i] = upd_target;
                m_ctr[i] = CTR_HALF;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("busy", {31'h0, busy}, {31'h0, (m_rem > 0)});
        chk("pred_valid", {31'h0, pred_valid}, {31'h0, m_pv});
        chk("pred_taken", {31'h0, pred_taken}, {31'h0, m_pt});
        if (m_ptgt_known) chk("pred_target", pred_target, m_ptgt);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        lookup_valid = 0; lookup_pc = 0; stall = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        flush_all = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
        cyc();
        upd_valid = 0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_valid = 1; lookup_pc = pc;
        cyc();
        lookup_valid = 0;
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
            | $urandom_range(0, 3);
        if ($urandom % 4 == 0) p = p | 32'h0010_0000;
        return p;
    endfunction

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_known[i] = 0; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        set_idle();
        rst_n = 0;

        // Reset and clear sequence
        lookup_valid = 1; lookup_pc = 32'h100;
        cyc(); cyc();
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_pred_valid", {31'h0, pred_valid}, 32'h0);
        chk("rst_pred_target", pred_target, 32'h0);
        rst_n = 1;
        repeat (15) cyc();
        chk("clear_busy_15", {31'h0, busy}, 32'h1);
        chk("clear_pred_taken", {31'h0, pred_taken}, 32'h0);
        cyc();
        chk("clear_done_16", {31'h0, busy}, 32'h0);
        look(32'h100);
        chk("first_lookup_valid", {31'h0, pred_valid}, 32'h1);
        chk("first_lookup_taken", {31'h0, pred_taken}, 32'h0);

        // Allocate
        upd(32'h100, 1, 32'h200);
        look(32'h100);
        chk("alloc_taken", {31'h0, pred_taken}, 32'h1);
        chk("alloc_target", pred_target, 32'h200);

        // Saturation at both ends
        upd(32'h100, 0, 0); upd(32'h100, 0, 0);
        look(32'h100);
        chk("sat_ctr0", {31'h0, pred_taken}, 32'h0);
        upd(32'h100, 0, 0);
        upd(32'h100, 1, 32'h200);
        look(32'h100);
        chk("sat_low_hold", {31'h0, pred_taken}, 32'h0);
        upd(32'h100, 1, 32'h200); upd(32'h100, 1, 32'h200);
        look(32'h100);
        chk("sat_ctr3", {31'h0, pred_taken}, 32'h1);
        upd(32'h100, 1, 32'h200);
        upd(32'h100, 0, 0);
        look(32'h100);
        chk("sat_high_hold", {31'h0, pred_taken}, 32'h1);

        // Alias and eviction
        look(32'h140);
        chk("alias_miss", {31'h0, pred_taken}, 32'h0);
        upd(32'h140, 1, 32'h300);
        look(32'h100);
        chk("evicted_miss", {31'h0, pred_taken}, 32'h0);
        look(32'h140);
        chk("evictor_target", pred_target, 32'h300);

        // Same-cycle lookup and allocating update
        lookup_valid = 1; lookup_pc = 32'h1C4;
        upd(32'h1C4, 1, 32'h444);
        chk("collide_old", {31'h0, pred_taken}, 32'h0);
        cyc();
        chk("collide_new", {31'h0, pred_taken}, 32'h1);
        chk("collide_target", pred_target, 32'h444);

        // Stall holds outputs
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            lookup_pc = 32'h100 + 32'(k * 4);
            lookup_valid = (k != 1);
            cyc();
            chk("stall_taken", {31'h0, pred_taken}, 32'h1);
            chk("stall_target", pred_target, 32'h444);
        end
        stall = 0;
        set_idle();

        // Flush mid-operation
        upd(32'h100, 1, 32'h500);
        upd(32'h104, 1, 32'h504);
        upd(32'h108, 1, 32'h508);
        flush_all = 1;
        cyc();
        flush_all = 0;
        chk("flush_busy", {31'h0, busy}, 32'h1);
        repeat (4) cyc();
        upd(32'h10C, 1, 32'h999);
        repeat (10) cyc();
        chk("flush_busy_15", {31'h0, busy}, 32'h1);
        cyc();
        chk("flush_done", {31'h0, busy}, 32'h0);
        look(32'h100);
        chk("flushed_100", {31'h0, pred_taken}, 32'h0);
        look(32'h104);
        chk("flushed_104", {31'h0, pred_taken}, 32'h0);
        look(32'h108);
        chk("flushed_108", {31'h0, pred_taken}, 32'h0);
        look(32'h10C);
        chk("dropped_upd", {31'h0, pred_taken}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom % 700) != 0;
            stall        = ($urandom % 8) == 0;
            flush_all    = ($urandom % 80) == 0;
            lookup_valid = ($urandom % 4) != 0;
            lookup_pc    = rpc();
            upd_valid    = ($urandom % 2) == 0;
            upd_pc       = rpc();
            upd_taken    = ($urandom % 3) != 0;
            upd_target   = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
